// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch + data) in front of a single 16-bit synchronous-write memory.
// Byte writes are done as read-modify-write because the memory has no byte enables.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic [15:0] mem_address,
  output logic        mem_we,
  output logic [7:0]  mem_data_write_high,
  output logic [7:0]  mem_data_write_low,
  input  logic [7:0]  mem_data_read_high,
  input  logic [7:0]  mem_data_read_low
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  state_t      state_q;
  logic        last_grant_q;
  logic        owner_q;
  logic        if_ack_q;
  logic        d_ack_q;
  logic [15:0] if_rdata_q;
  logic [15:0] d_rdata_q;
  logic [15:0] mem_address_q;
  logic        mem_we_q;
  logic [7:0]  wdata_high_q;
  logic [7:0]  wdata_low_q;

  logic        if_elig;
  logic        d_elig;
  logic        grant_data;
  logic        grant_fetch;
  logic [15:0] rd_word;
  logic [15:0] d_rdata_d;
  logic [15:0] merge_d;
  logic        unused_if_addr0;

  assign unused_if_addr0 = if_addr[0];

  // A port acknowledged this cycle sits out arbitration so a held req is not regranted.
  assign if_elig     = if_req && !if_ack_q;
  assign d_elig      = d_req && !d_ack_q;
  assign grant_data  = d_elig && (!if_elig || (last_grant_q == PORT_FETCH));
  assign grant_fetch = if_elig && !grant_data;

  assign rd_word   = {mem_data_read_high, mem_data_read_low};
  assign d_rdata_d = d_byte ? {8'h00, (d_addr[0] ? mem_data_read_high : mem_data_read_low)}
                            : rd_word;
  assign merge_d   = d_addr[0] ? {d_wdata[7:0], mem_data_read_low}
                               : {mem_data_read_high, d_wdata[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= PORT_FETCH;
      owner_q       <= PORT_FETCH;
      if_ack_q      <= 1'b0;
      d_ack_q       <= 1'b0;
      if_rdata_q    <= 16'h0000;
      d_rdata_q     <= 16'h0000;
      mem_address_q <= 16'h0000;
      mem_we_q      <= 1'b0;
      wdata_high_q  <= 8'h00;
      wdata_low_q   <= 8'h00;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_data) begin
            mem_address_q <= {d_addr[15:1], 1'b0};
            owner_q       <= PORT_DATA;
            last_grant_q  <= PORT_DATA;
            if (d_we && !d_byte) begin
              wdata_high_q <= d_wdata[15:8];
              wdata_low_q  <= d_wdata[7:0];
              mem_we_q     <= 1'b1;
              state_q      <= WR;
            end else begin
              mem_we_q <= 1'b0;
              state_q  <= RD;
            end
          end else if (grant_fetch) begin
            mem_address_q <= {if_addr[15:1], 1'b0};
            owner_q       <= PORT_FETCH;
            last_grant_q  <= PORT_FETCH;
            mem_we_q      <= 1'b0;
            state_q       <= RD;
          end
        end
        RD: begin
          if (owner_q == PORT_FETCH) begin
            if_rdata_q <= rd_word;
            if_ack_q   <= 1'b1;
            state_q    <= IDLE;
          end else if (d_we) begin
            // Byte write: splice the new byte into the word just read.
            wdata_high_q <= merge_d[15:8];
            wdata_low_q  <= merge_d[7:0];
            mem_we_q     <= 1'b1;
            state_q      <= WR;
          end else begin
            d_rdata_q <= d_rdata_d;
            d_ack_q   <= 1'b1;
            state_q   <= IDLE;
          end
        end
        WR: begin
          mem_we_q <= 1'b0;
          d_ack_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          mem_we_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign if_ack              = if_ack_q;
  assign d_ack               = d_ack_q;
  assign if_rdata            = if_rdata_q;
  assign d_rdata             = d_rdata_q;
  assign mem_address         = mem_address_q;
  assign mem_we              = mem_we_q;
  assign mem_data_write_high = wdata_high_q;
  assign mem_data_write_low  = wdata_low_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural word memory and hand-computed expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic        d_byte;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic [15:0] mem_address;
  logic        mem_we;
  logic [7:0]  mem_data_write_high;
  logic [7:0]  mem_data_write_low;
  logic [7:0]  mem_data_read_high;
  logic [7:0]  mem_data_read_low;

  logic [15:0] mem [0:32767];
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [15:0] bd_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Backdoor preload shares the single write process with the DUT write port.
  always @(posedge clk) begin
    if (bd_we)
      mem[bd_addr[15:1]] <= bd_data;
    else if (mem_we)
      mem[mem_address[15:1]] <= {mem_data_write_high, mem_data_write_low};
  end

  assign mem_data_read_high = mem[mem_address[15:1]][15:8];
  assign mem_data_read_low  = mem[mem_address[15:1]][7:0];

  mem_arbiter dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .if_req              (if_req),
    .if_addr             (if_addr),
    .if_ack              (if_ack),
    .if_rdata            (if_rdata),
    .d_req               (d_req),
    .d_we                (d_we),
    .d_byte              (d_byte),
    .d_addr              (d_addr),
    .d_wdata             (d_wdata),
    .d_ack               (d_ack),
    .d_rdata             (d_rdata),
    .mem_address         (mem_address),
    .mem_we              (mem_we),
    .mem_data_write_high (mem_data_write_high),
    .mem_data_write_low  (mem_data_write_low),
    .mem_data_read_high  (mem_data_read_high),
    .mem_data_read_low   (mem_data_read_low)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %s observed=%h expected=%h ok", tag, obs, exp);
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    tick();
    bd_we   = 1'b0;
  endtask

  task automatic set_d(input logic we, input logic byt, input logic [15:0] a, input logic [15:0] wd);
    d_we    = we;
    d_byte  = byt;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 16'h0000;
    d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
    bd_we = 1'b0; bd_addr = 16'h0000; bd_data = 16'h0000;
    #2;
    preload(16'h0020, 16'h1111);
    preload(16'h0030, 16'h2222);
    preload(16'h0010, 16'h1234);
    preload(16'hFFFE, 16'hBEEF);
    preload(16'h0040, 16'h5678);
    preload(16'h0050, 16'h0000);
    preload(16'h000C, 16'h0000);

    // Requests held during reset must not start anything.
    if_req = 1'b1; if_addr = 16'h0020;
    set_d(1'b0, 1'b0, 16'h0030, 16'h0000);
    tick(); tick();
    chk("rst_mem_address", mem_address, 16'h0000);
    chk("rst_mem_we", {15'd0, mem_we}, 16'h0000);
    chk("rst_if_ack", {15'd0, if_ack}, 16'h0000);
    chk("rst_d_ack", {15'd0, d_ack}, 16'h0000);
    chk("rst_if_rdata", if_rdata, 16'h0000);
    chk("rst_d_rdata", d_rdata, 16'h0000);
    chk("rst_wdata", {mem_data_write_high, mem_data_write_low}, 16'h0000);

    // Tie from reset: data first, then alternation while both held.
    rst_n = 1'b1;
    tick();
    chk("tie_data_first_addr", mem_address, 16'h0030);
    chk("tie_rd_no_we", {15'd0, mem_we}, 16'h0000);
    tick();
    chk("tie_d_ack", {15'd0, d_ack}, 16'h0001);
    chk("tie_d_rdata", d_rdata, 16'h2222);
    chk("tie_if_ack_quiet", {15'd0, if_ack}, 16'h0000);
    tick();
    chk("alt_fetch_addr", mem_address, 16'h0020);
    chk("alt_d_ack_low", {15'd0, d_ack}, 16'h0000);
    tick();
    chk("alt_if_ack", {15'd0, if_ack}, 16'h0001);
    chk("alt_if_rdata", if_rdata, 16'h1111);
    tick();
    chk("alt_data_again", mem_address, 16'h0030);
    tick();
    chk("alt_d_ack2", {15'd0, d_ack}, 16'h0001);
    d_req = 1'b0;
    tick();
    chk("alt_fetch_again", mem_address, 16'h0020);
    tick();
    chk("alt_if_ack2", {15'd0, if_ack}, 16'h0001);
    if_req = 1'b0;
    tick();
    // Fresh tie with last grant = fetch: data wins.
    if_req = 1'b1; d_req = 1'b1;
    tick();
    chk("tie2_data_wins", mem_address, 16'h0030);
    tick();
    chk("tie2_d_ack", {15'd0, d_ack}, 16'h0001);
    if_req = 1'b0; d_req = 1'b0;
    tick();
    // Fresh tie with last grant = data: fetch wins.
    if_req = 1'b1; d_req = 1'b1;
    tick();
    chk("tie3_fetch_wins", mem_address, 16'h0020);
    tick();
    chk("tie3_if_ack", {15'd0, if_ack}, 16'h0001);
    chk("tie3_d_ack_low", {15'd0, d_ack}, 16'h0000);
    if_req = 1'b0; d_req = 1'b0;
    tick();
    tick();

    // Word write then word read at 0x000C.
    set_d(1'b1, 1'b0, 16'h000C, 16'hA55A);
    tick();
    chk("ww_mem_we", {15'd0, mem_we}, 16'h0001);
    chk("ww_addr", mem_address, 16'h000C);
    chk("ww_wdata", {mem_data_write_high, mem_data_write_low}, 16'hA55A);
    tick();
    chk("ww_d_ack", {15'd0, d_ack}, 16'h0001);
    chk("ww_we_drop", {15'd0, mem_we}, 16'h0000);
    chk("ww_mem_word", mem[15'h0006], 16'hA55A);
    d_req = 1'b0;
    tick();
    set_d(1'b0, 1'b0, 16'h000C, 16'h0000);
    tick();
    chk("wr_no_ack_yet", {15'd0, d_ack}, 16'h0000);
    tick();
    chk("wr_d_ack", {15'd0, d_ack}, 16'h0001);
    chk("wr_d_rdata", d_rdata, 16'hA55A);
    d_req = 1'b0;
    tick();

    // Fetch from odd address, req held through the ack.
    if_addr = 16'h000D; if_req = 1'b1;
    tick();
    chk("fodd_addr", mem_address, 16'h000C);
    tick();
    chk("fodd_if_ack", {15'd0, if_ack}, 16'h0001);
    chk("fodd_if_rdata", if_rdata, 16'hA55A);
    tick();
    chk("held_ack_clear", {15'd0, if_ack}, 16'h0000);
    tick();
    chk("held_no_regrant", {15'd0, if_ack}, 16'h0000);
    tick();
    chk("held_regrant_next", {15'd0, if_ack}, 16'h0001);
    if_req = 1'b0;
    tick();

    // Byte RMW to 0x0011.
    set_d(1'b1, 1'b1, 16'h0011, 16'h00FF);
    tick();
    chk("rmw_addr", mem_address, 16'h0010);
    chk("rmw_rd_no_we", {15'd0, mem_we}, 16'h0000);
    tick();
    chk("rmw_we", {15'd0, mem_we}, 16'h0001);
    chk("rmw_merge", {mem_data_write_high, mem_data_write_low}, 16'hFF34);
    chk("rmw_no_ack_yet", {15'd0, d_ack}, 16'h0000);
    tick();
    chk("rmw_d_ack", {15'd0, d_ack}, 16'h0001);
    chk("rmw_we_drop", {15'd0, mem_we}, 16'h0000);
    chk("rmw_mem_word", mem[15'h0008], 16'hFF34);
    d_req = 1'b0;
    tick();
    set_d(1'b0, 1'b1, 16'h0010, 16'h0000);
    tick(); tick();
    chk("br_low_ack", {15'd0, d_ack}, 16'h0001);
    chk("br_low_rdata", d_rdata, 16'h0034);
    d_req = 1'b0;
    tick();
    set_d(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    tick();
    chk("br_top_addr", mem_address, 16'hFFFE);
    tick();
    chk("br_top_rdata", d_rdata, 16'h00BE);
    chk("if_rdata_untouched", if_rdata, 16'hA55A);
    d_req = 1'b0;
    tick();

    // Reset while an RMW sits in RD.
    set_d(1'b1, 1'b1, 16'h0040, 16'h0099);
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_rd_we", {15'd0, mem_we}, 16'h0000);
    chk("abort_rd_addr", mem_address, 16'h0000);
    tick(); tick();
    chk("abort_rd_word", mem[15'h0020], 16'h5678);
    chk("abort_rd_no_ack", {15'd0, d_ack}, 16'h0000);
    d_req = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("abort_rd_after", {15'd0, d_ack}, 16'h0000);

    // Reset while a word write sits in WR: mem_we drops without a clock.
    set_d(1'b1, 1'b0, 16'h0050, 16'h1357);
    tick();
    chk("abort_wr_we_high", {15'd0, mem_we}, 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("abort_wr_async_drop", {15'd0, mem_we}, 16'h0000);
    tick();
    chk("abort_wr_word", mem[15'h0028], 16'h0000);
    d_req = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("abort_wr_no_ack", {15'd0, d_ack}, 16'h0000);

    // Block is idle again and serves a fetch in one edge.
    if_addr = 16'h0020; if_req = 1'b1;
    tick();
    chk("post_rst_fetch_addr", mem_address, 16'h0020);
    tick();
    chk("post_rst_if_rdata", if_rdata, 16'h1111);
    if_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
